// File: rtl/cache_types.sv
// Shared coherence types: response-bus message format and arbiter FSM states.
package cache_types;

  typedef struct packed {
    logic        valid;
    logic [2:0]  msg_type;
    logic [3:0]  source;
    logic [2:0]  way;
    logic [31:0] addr;
  } resp_msg_t;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BCAST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req bit searching upward from ptr,
// wrapping N-1 -> 0; N need not be a power of two.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [W:0]   sum_s;
  logic [W-1:0] cand_s;
  logic         hit_s;

  // Scan N candidates starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s         = {1'b0, ptr_i} + (W+1)'(i);
      cand_s        = (sum_s >= (W+1)'(N)) ? W'(sum_s - (W+1)'(N)) : W'(sum_s);
      hit_s         = ~any_o & req_i[cand_s];
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o         = hit_s ? cand_s : idx_o;
      any_o         = any_o | hit_s;
    end
  end

endmodule

// File: rtl/resp_bus_arbiter.sv
// Coherence response-bus arbiter: round-robin grant in ARB, one-cycle broadcast
// of the granted message in BCAST; any busy line stalls new grants.
module resp_bus_arbiter
  import cache_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       resp_bus_req,
  input  resp_msg_t [NUM_REQ-1:0]  resp_bus_tx,
  input  logic [NUM_REQ-1:0]       resp_bus_busy,
  output logic [NUM_REQ-1:0]       resp_bus_gnt,
  output resp_msg_t                resp_bus_msg,
  output logic [IDX_W-1:0]         bus_owner
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  resp_msg_t          msg_q, msg_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               busy_any_s;
  logic               grant_s;

  rr_priority_picker #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_picker (
    .req_i (resp_bus_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign busy_any_s = |resp_bus_busy;
  assign grant_s    = (state_q == ARB) && !busy_any_s && pick_any_s && !rst;

  // Next-state: latch the winner's message on a grant; drop valid after BCAST.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    msg_d    = msg_q;
    case (state_q)
      ARB: begin
        if (grant_s) begin
          msg_d       = resp_bus_tx[pick_idx_s];
          msg_d.valid = 1'b1;
          owner_d     = pick_idx_s;
          rr_ptr_d    = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDX_W'(1);
          state_d     = BCAST;
        end else begin
          state_d = ARB;
        end
      end
      BCAST: begin
        msg_d.valid = 1'b0;
        state_d     = ARB;
      end
      default: begin
        msg_d.valid = 1'b0;
        state_d     = ARB;
      end
    endcase
  end

  // State, pointer, owner and broadcast registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      msg_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      msg_q    <= msg_d;
    end
  end

  assign resp_bus_gnt = grant_s ? pick_gnt_s : '0;
  assign resp_bus_msg = msg_q;
  assign bus_owner    = owner_q;

endmodule

// File: tb/tb_resp_bus_arbiter.sv
// Directed bench for resp_bus_arbiter (4-agent and 3-agent instances).
module tb_resp_bus_arbiter;
  import cache_types::*;

  logic            clk;
  logic            rst;
  logic [3:0]      req;
  resp_msg_t [3:0] tx;
  logic [3:0]      busy;
  logic [3:0]      gnt;
  resp_msg_t       msg;
  logic [1:0]      owner;

  logic [2:0]      req3;
  resp_msg_t [2:0] tx3;
  logic [2:0]      busy3;
  logic [2:0]      gnt3;
  resp_msg_t       msg3;
  logic [1:0]      owner3;

  int total;
  int bad;

  resp_bus_arbiter #(.NUM_REQ(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .resp_bus_req  (req),
    .resp_bus_tx   (tx),
    .resp_bus_busy (busy),
    .resp_bus_gnt  (gnt),
    .resp_bus_msg  (msg),
    .bus_owner     (owner)
  );

  resp_bus_arbiter #(.NUM_REQ(3)) dut3 (
    .clk           (clk),
    .rst           (rst),
    .resp_bus_req  (req3),
    .resp_bus_tx   (tx3),
    .resp_bus_busy (busy3),
    .resp_bus_gnt  (gnt3),
    .resp_bus_msg  (msg3),
    .bus_owner     (owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    req = 4'b1111;
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
    tick();
    total++;
    if (msg !== resp_msg_t'(0)) begin bad++; $display("FAIL reset_msg got=%h exp=0", msg); end
    req = 4'b0000;
    rst = 1'b0;
    tick();
    total++;
    if (dut.state_q !== ARB) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ARB); end
    total++;
    if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.rr_ptr_q); end
    total++;
    if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_single;
    req = 4'b0100;
    #1;
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
    tick();
    req = 4'b0000;
    total++;
    if (msg.valid !== 1'b1 || msg.addr !== 32'h1000_0040) begin
      bad++; $display("FAIL single_msg got=v%b/%h exp=v1/10000040", msg.valid, msg.addr);
    end
    total++;
    if (owner !== 2'd2) begin bad++; $display("FAIL single_owner got=%0d exp=2", owner); end
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL single_bcast_gnt got=%b exp=0000", gnt); end
    tick();
    total++;
    if (msg.valid !== 1'b0 || msg.addr !== 32'h1000_0040) begin
      bad++; $display("FAIL single_after got=v%b/%h exp=v0/10000040", msg.valid, msg.addr);
    end
    total++;
    if (dut.rr_ptr_q !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d exp=3", dut.rr_ptr_q); end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd3; exp_seq[1] = 2'd0; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
    req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++;
      if (gnt !== (4'b0001 << exp_seq[n])) begin
        bad++; $display("FAIL wrap_gnt%0d got=%b exp=%b", n, gnt, 4'b0001 << exp_seq[n]);
      end
      tick();
      total++;
      if (owner !== exp_seq[n] || msg.valid !== 1'b1) begin
        bad++; $display("FAIL wrap_owner%0d got=%0d/v%b exp=%0d/v1", n, owner, msg.valid, exp_seq[n]);
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (gnt !== (4'b0001 << k)) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, 4'b0001 << k); end
      tick();
      req[k] = 1'b0;
      #1;
      total++;
      if (msg.valid !== 1'b1 || msg.source !== 4'(k) || msg.addr !== 32'h2000_0000 + 32'(k)) begin
        bad++; $display("FAIL rr_msg%0d got=v%b/src%0d/%h exp=v1/src%0d", k, msg.valid, msg.source, msg.addr, k);
      end
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_bcast_gnt%0d got=%b exp=0000", k, gnt); end
      tick();
    end
    #1;
    total++;
    if (gnt !== 4'b0000 || msg.valid !== 1'b0) begin
      bad++; $display("FAIL rr_idle got=%b/v%b exp=0000/v0", gnt, msg.valid);
    end
  endtask

  task automatic test_busy;
    req  = 4'b0001;
    busy = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL busy_stall%0d got=%b exp=0000", c, gnt); end
      tick();
    end
    busy = 4'b0000;
    #1;
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL busy_release got=%b exp=0001", gnt); end
    tick();
    busy = 4'b1111;
    req  = 4'b0000;
    #1;
    total++;
    if (msg.valid !== 1'b1 || dut.state_q !== BCAST) begin
      bad++; $display("FAIL busy_bcast got=v%b/st%0d exp=v1/st1", msg.valid, dut.state_q);
    end
    tick();
    req = 4'b0001;
    #1;
    total++;
    if (dut.state_q !== ARB || msg.valid !== 1'b0 || gnt !== 4'b0000) begin
      bad++; $display("FAIL busy_after got=st%0d/v%b/%b exp=st0/v0/0000", dut.state_q, msg.valid, gnt);
    end
    busy = 4'b0000;
    req  = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset;
    req = 4'b0100;
    #1;
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL areset_gnt got=%b exp=0100", gnt); end
    tick();
    total++;
    if (msg.valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=v%b exp=v1", msg.valid); end
    req = 4'b0000;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (msg.valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=v%b exp=v0", msg.valid); end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (dut.state_q !== ARB || dut.rr_ptr_q !== 2'd0) begin
      bad++; $display("FAIL areset_state got=st%0d/p%0d exp=st0/p0", dut.state_q, dut.rr_ptr_q);
    end
    tick();
    total++;
    if (msg.valid !== 1'b0) begin bad++; $display("FAIL areset_no_rebcast got=v%b exp=v0", msg.valid); end
  endtask

  task automatic test_three_agents;
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd0;
    req3 = 3'b111;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++;
      if (gnt3 !== (3'b001 << exp_seq[n])) begin
        bad++; $display("FAIL n3_gnt%0d got=%b exp=%b", n, gnt3, 3'b001 << exp_seq[n]);
      end
      tick();
      total++;
      if (owner3 !== exp_seq[n] || msg3.valid !== 1'b1) begin
        bad++; $display("FAIL n3_owner%0d got=%0d/v%b exp=%0d/v1", n, owner3, msg3.valid, exp_seq[n]);
      end
      if (n == 2) begin
        total++;
        if (dut3.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL n3_wrap_ptr got=%0d exp=0", dut3.rr_ptr_q); end
      end
      tick();
    end
    req3 = 3'b000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    busy  = 4'b0000;
    tx    = '0;
    req3  = 3'b000;
    busy3 = 3'b000;
    tx3   = '0;
    for (int k = 0; k < 4; k++) begin
      tx[k].source   = 4'(k);
      tx[k].way      = 3'(k + 1);
      tx[k].msg_type = 3'd5;
      tx[k].addr     = 32'h2000_0000 + 32'(k);
    end
    for (int k = 0; k < 3; k++) begin
      tx3[k].source = 4'(k);
      tx3[k].addr   = 32'h3000_0000 + 32'(k);
    end
    tx[2].addr = 32'h1000_0040;
    tick();

    test_reset();
    test_single();
    test_wrap();
    tx[2].addr = 32'h2000_0002;
    pulse_reset();
    test_round_robin();
    test_busy();
    tx[2].addr = 32'h1000_0040;
    test_async_reset();
    test_three_agents();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
